core_lsu: RTL and testbench
===========================

# core_lsu

Load/store unit sitting directly downstream of the core's fetch/decode stage. It accepts one decoded RV32I load or store (effective address already computed, store data, funct3, rd), drives a req/gnt/rvalid data-memory port with correct byte enables and lane steering, and returns sign- or zero-extended load data for register writeback. Misaligned accesses, illegal funct3 and memory timeouts are reported as exceptions with RISC-V cause codes; the core stalls on `req_ready_o` and `done_o`.

## Interface
- `XLEN`, 32: data and address width.
- `TIMEOUT_CYCLES`, 0: maximum cycles spent in REQ or WAIT before an access fault; 0 disables the check.

- `clk_i` in 1: clock.
- `rst_i` in 1: reset, asynchronous, active-high.
- `req_valid_i` in 1: decode presents an operation.
- `req_ready_o` out 1: LSU can accept an operation (IDLE only).
- `req_store_i` in 1: 1 = store, 0 = load.
- `req_funct3_i` in 3: LB/LH/LW/LBU/LHU or SB/SH/SW encoding.
- `req_addr_i` in XLEN: effective byte address.
- `req_wdata_i` in XLEN: rs2 value.
- `req_rd_i` in 5: load destination register.
- `mem_req_o` out 1: memory request.
- `mem_gnt_i` in 1: request accepted.
- `mem_we_o` out 1: write enable.
- `mem_be_o` out 4: byte enables.
- `mem_addr_o` out XLEN: word-aligned address (bits [1:0] = 0).
- `mem_wdata_o` out XLEN: lane-steered store data.
- `mem_rvalid_i` in 1: response valid; sent for loads and stores.
- `mem_rdata_i` in XLEN: read word.
- `wb_valid_o` out 1: one-cycle writeback pulse, loads only.
- `wb_rd_o` out 5: writeback register.
- `wb_data_o` out XLEN: extended load data.
- `done_o` out 1: one-cycle pulse when any operation retires, including errors.
- `err_valid_o` out 1: one-cycle exception pulse, coincident with `done_o`.
- `err_cause_o` out 4: 2 illegal, 4 load misaligned, 5 load access fault, 6 store misaligned, 7 store access fault.
- `err_tval_o` out XLEN: faulting byte address.

## Operation
- **States:**
  - IDLE: `req_ready_o` = 1.
  - REQ: `mem_req_o` held until `mem_gnt_i`.
  - WAIT: awaiting `mem_rvalid_i`.
  - RESP: outputs the retirement pulses, then returns to IDLE.
- **IDLE on `req_valid_i`:**
  - The operation is latched.
  - Illegal funct3 (load 011/110/111; store ≥ 011): go to RESP with cause 2.
  - Misaligned access (halfword with addr[0] = 1, word with addr[1:0] ≠ 0): go to RESP with cause 4 or 6. No memory request is issued.
  - Otherwise go to REQ.
- **REQ/WAIT outputs:** `mem_addr_o`, `mem_be_o`, `mem_we_o` and `mem_wdata_o` are registered and stable until grant.
  - Byte enables: byte 0001<<a[1:0]; half 0011<<a[1:0]; word 1111.
  - Store data: replicated into lanes (byte ×4, half ×2).
- **Transitions:**
  - REQ & `mem_gnt_i` → WAIT.
  - WAIT & `mem_rvalid_i` → RESP.
  - Loads capture the extracted lane at `mem_rvalid_i`; LB/LH sign-extend, LBU/LHU zero-extend.
- **RESP:**
  - Always pulses `done_o`.
  - Loads without error also pulse `wb_valid_o`. rd = 0 is still presented; the register file discards it.
  - Error outputs are valid only while `err_valid_o` = 1; otherwise they hold 0.
- **Timeout:** a counter is cleared on entry to REQ and on entry to WAIT. When it reaches `TIMEOUT_CYCLES` (nonzero), go to RESP with cause 5/7 and drop `mem_req_o`. A late `mem_rvalid_i` is ignored.
- **Stray responses:** `mem_rvalid_i` outside WAIT is ignored.

## Timing
- **Reset values:** state IDLE, all outputs 0 except `req_ready_o` = 1. Reset is asynchronous, so `mem_req_o` drops in the same cycle `rst_i` rises. Any outstanding transaction is abandoned; memory shares `rst_i`.
- **Best-case latency:**
  - Accept at cycle 0, `mem_req_o` at cycle 1.
  - Grant in cycle 1, `mem_rvalid_i` in cycle 2.
  - `done_o`/`wb_valid_o` in cycle 3.
- **Error latency:** decode errors retire in cycle 1.
- **Throughput:** one operation is in flight. The next accept is the cycle after RESP.
- **Grant timing:** `mem_gnt_i` may arrive in the first REQ cycle or later. `mem_rvalid_i` must not arrive in the grant cycle.

## Structure
- **`riscv_pkg` additions:**
  - Load/store funct3 constants: F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU, F3_SB, F3_SH, F3_SW.
  - Exception cause constants.
  - `lsu_state_e` enum.
- **Sub-module `core_lsu_align`:** purely combinational. It produces `mem_be_o` and store-lane steering from funct3/addr, and load lane extraction plus extension from rdata/funct3/addr[1:0].

## Test plan
- LW at 0x100, gnt in cycle 1, rdata 0xDEADBEEF, rd = 5 → `wb_valid_o` in cycle 3 with rd = 5, data 0xDEADBEEF; `mem_be_o` = 1111.
- LB at 0x103, rdata 0x80FF0000 → `mem_be_o` = 1000, `wb_data_o` = 0xFFFFFF80. LBU at the same address → 0x00000080.
- SH at 0x202, wdata 0x0000ABCD, `mem_gnt_i` delayed 3 cycles → `mem_req_o` and all mem outputs held; addr 0x200, be 1100, wdata 0xABCDABCD; `done_o` pulses with no `wb_valid_o`.
- LW at 0x101 → no `mem_req_o`; in cycle 1 `err_valid_o`, cause 4, tval 0x101. Store funct3 = 011 → cause 2.
- `TIMEOUT_CYCLES` = 4, load never granted → after 4 REQ cycles, cause 5 and `mem_req_o` = 0. A later stray `mem_rvalid_i` is ignored.
- `rst_i` asserted in WAIT → `mem_req_o` and all pulses 0 immediately, `req_ready_o` = 1; a subsequent LW completes normally.

Source files
------------

// File: rtl/core_lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : core_lsu_pkg
// Description : Shared types and constants for the core load/store unit.
//               Contains the RV32I load/store funct3 encodings, the exception
//               cause codes, the LSU state enum and two decode helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package core_lsu_pkg;

  // Load/store funct3 encodings (RV32I)
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // Exception cause codes
  localparam logic [3:0] CAUSE_ILLEGAL          = 4'd2;
  localparam logic [3:0] CAUSE_LOAD_MISALIGNED  = 4'd4;
  localparam logic [3:0] CAUSE_LOAD_FAULT       = 4'd5;
  localparam logic [3:0] CAUSE_STORE_MISALIGNED = 4'd6;
  localparam logic [3:0] CAUSE_STORE_FAULT      = 4'd7;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_WAIT = 2'd2,
    LSU_RESP = 2'd3
  } lsu_state_e;

  // Stores only encode SB/SH/SW; loads add the unsigned byte/half forms.
  function automatic logic lsu_f3_legal(input logic store, input logic [2:0] f3);
    if (store) begin
      return (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
    end
    return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
           (f3 == F3_LBU) || (f3 == F3_LHU);
  endfunction

  // funct3[1:0] is the access size for every legal encoding.
  function automatic logic lsu_misaligned(input logic [2:0] f3, input logic [1:0] a);
    return ((f3[1:0] == 2'b01) && a[0]) || ((f3[1:0] == 2'b10) && (a != 2'b00));
  endfunction

endpackage
`default_nettype wire

// File: rtl/core_lsu_if.sv
`default_nettype none
// ============================================================================
// Module      : core_lsu_if
// Description : req/gnt/rvalid data-memory port.
//   mem_req    LSU -> mem : request, held until mem_gnt
//   mem_gnt    mem -> LSU : request accepted
//   mem_we     LSU -> mem : write enable
//   mem_be     LSU -> mem : byte enables
//   mem_addr   LSU -> mem : word-aligned address
//   mem_wdata  LSU -> mem : lane-steered store data
//   mem_rvalid mem -> LSU : response valid (loads and stores)
//   mem_rdata  mem -> LSU : read word
// Revision    : 1.0 - initial release
// ============================================================================
interface core_lsu_if #(
  parameter int XLEN = 32
);
  logic            mem_req;
  logic            mem_gnt;
  logic            mem_we;
  logic [3:0]      mem_be;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic            mem_rvalid;
  logic [XLEN-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface
`default_nettype wire

// File: rtl/core_lsu_align.sv
`default_nettype none
// ============================================================================
// Module      : core_lsu_align
// Description : Combinational lane logic for the LSU.
//   funct3_i   : access encoding
//   addr_lo_i  : byte offset within the word
//   wdata_i    : raw store data (rs2)
//   rdata_i    : raw read word from memory
//   be_o       : byte enables
//   wdata_o    : store data replicated into every lane
//   rdata_o    : selected load lane, sign/zero extended
// Revision    : 1.0 - initial release
// ============================================================================
module core_lsu_align
  import core_lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3_i,
  input  logic [1:0]      addr_lo_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic [XLEN-1:0] rdata_i,
  output logic [3:0]      be_o,
  output logic [XLEN-1:0] wdata_o,
  output logic [XLEN-1:0] rdata_o
);

  logic [XLEN-1:0] w_shifted;

  // Bring the addressed lane down to bit 0 before extension.
  assign w_shifted = rdata_i >> {addr_lo_i, 3'b000};

  always_comb begin
    be_o    = 4'b1111;
    wdata_o = wdata_i;
    case (funct3_i[1:0])
      2'b00: begin
        be_o    = 4'b0001 << addr_lo_i;
        wdata_o = {(XLEN/8){wdata_i[7:0]}};
      end
      2'b01: begin
        be_o    = 4'b0011 << addr_lo_i;
        wdata_o = {(XLEN/16){wdata_i[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    rdata_o = rdata_i;
    case (funct3_i)
      F3_LB:   rdata_o = {{(XLEN-8){w_shifted[7]}}, w_shifted[7:0]};
      F3_LH:   rdata_o = {{(XLEN-16){w_shifted[15]}}, w_shifted[15:0]};
      F3_LBU:  rdata_o = {{(XLEN-8){1'b0}}, w_shifted[7:0]};
      F3_LHU:  rdata_o = {{(XLEN-16){1'b0}}, w_shifted[15:0]};
      default: rdata_o = rdata_i;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/core_lsu.sv
`default_nettype none
// ============================================================================
// Module      : core_lsu
// Description : RV32I load/store unit. Accepts one decoded load/store, runs it
//               over the req/gnt/rvalid memory port and retires it with a
//               done pulse, a load writeback pulse or an exception.
//   clk_i, rst_i        : clock, asynchronous active-high reset
//   req_*               : operation from decode (valid/ready handshake)
//   mem                 : data-memory port (master side)
//   wb_valid_o/rd/data  : load writeback
//   done_o              : retirement pulse (all operations)
//   err_valid_o/cause/tval : exception report
// Revision    : 1.0 - initial release
// ============================================================================
module core_lsu
  import core_lsu_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic            req_store_i,
  input  logic [2:0]      req_funct3_i,
  input  logic [XLEN-1:0] req_addr_i,
  input  logic [XLEN-1:0] req_wdata_i,
  input  logic [4:0]      req_rd_i,
  core_lsu_if.master      mem,
  output logic            wb_valid_o,
  output logic [4:0]      wb_rd_o,
  output logic [XLEN-1:0] wb_data_o,
  output logic            done_o,
  output logic            err_valid_o,
  output logic [3:0]      err_cause_o,
  output logic [XLEN-1:0] err_tval_o
);

  localparam int              c_cnt_w    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT_CYCLES - 1);
  localparam bit              c_to_en    = (TIMEOUT_CYCLES != 0);

  lsu_state_e r_state, w_next;

  logic               r_store, r_err, r_mem_we;
  logic [2:0]         r_funct3;
  logic [XLEN-1:0]    r_addr, r_mem_addr, r_mem_wdata, r_wb_data;
  logic [4:0]         r_rd;
  logic [3:0]         r_mem_be, r_cause;
  logic [c_cnt_w-1:0] r_cnt;

  logic            w_idle, w_resp, w_bad, w_expire, w_wb;
  logic [2:0]      w_al_f3;
  logic [1:0]      w_al_addr;
  logic [3:0]      w_be;
  logic [XLEN-1:0] w_wdata_lane, w_rdata_ext;

  assign w_idle   = (r_state == LSU_IDLE);
  assign w_resp   = (r_state == LSU_RESP);
  assign w_bad    = !lsu_f3_legal(req_store_i, req_funct3_i) ||
                    lsu_misaligned(req_funct3_i, req_addr_i[1:0]);
  assign w_expire = c_to_en && (r_cnt == c_cnt_last);

  // One lane unit serves both ends of an access: enables/steering are needed
  // at accept (from the request), extraction only in WAIT (from latched copy).
  assign w_al_f3   = w_idle ? req_funct3_i : r_funct3;
  assign w_al_addr = w_idle ? req_addr_i[1:0] : r_addr[1:0];

  core_lsu_align #(.XLEN(XLEN)) u_align (
    .funct3_i  (w_al_f3),
    .addr_lo_i (w_al_addr),
    .wdata_i   (req_wdata_i),
    .rdata_i   (mem.mem_rdata),
    .be_o      (w_be),
    .wdata_o   (w_wdata_lane),
    .rdata_o   (w_rdata_ext)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= LSU_IDLE;
    else       r_state <= w_next;
  end

  // Grant/response take priority over a timeout expiring in the same cycle.
  always_comb begin
    w_next = r_state;
    case (r_state)
      LSU_IDLE: if (req_valid_i) w_next = w_bad ? LSU_RESP : LSU_REQ;
      LSU_REQ:  if (mem.mem_gnt) w_next = LSU_WAIT;
                else if (w_expire) w_next = LSU_RESP;
      LSU_WAIT: if (mem.mem_rvalid || w_expire) w_next = LSU_RESP;
      LSU_RESP: w_next = LSU_IDLE;
      default:  w_next = LSU_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_store     <= 1'b0;
      r_err       <= 1'b0;
      r_mem_we    <= 1'b0;
      r_funct3    <= '0;
      r_addr      <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_wb_data   <= '0;
      r_rd        <= '0;
      r_mem_be    <= '0;
      r_cause     <= '0;
      r_cnt       <= '0;
    end else begin
      case (r_state)
        LSU_IDLE: if (req_valid_i) begin
          r_store     <= req_store_i;
          r_funct3    <= req_funct3_i;
          r_addr      <= req_addr_i;
          r_rd        <= req_rd_i;
          r_mem_we    <= req_store_i;
          r_mem_addr  <= {req_addr_i[XLEN-1:2], 2'b00};
          r_mem_be    <= w_be;
          r_mem_wdata <= w_wdata_lane;
          r_cnt       <= '0;
          r_err       <= w_bad;
          if (!lsu_f3_legal(req_store_i, req_funct3_i)) r_cause <= CAUSE_ILLEGAL;
          else r_cause <= req_store_i ? CAUSE_STORE_MISALIGNED : CAUSE_LOAD_MISALIGNED;
        end
        LSU_REQ: begin
          if (mem.mem_gnt) begin
            r_cnt <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
            if (w_expire) begin
              r_err   <= 1'b1;
              r_cause <= r_store ? CAUSE_STORE_FAULT : CAUSE_LOAD_FAULT;
            end
          end
        end
        LSU_WAIT: begin
          if (mem.mem_rvalid) begin
            r_wb_data <= w_rdata_ext;
          end else begin
            r_cnt <= r_cnt + 1'b1;
            if (w_expire) begin
              r_err   <= 1'b1;
              r_cause <= r_store ? CAUSE_STORE_FAULT : CAUSE_LOAD_FAULT;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign w_wb = w_resp && !r_store && !r_err;

  assign req_ready_o   = w_idle;
  assign mem.mem_req   = (r_state == LSU_REQ);
  assign mem.mem_we    = r_mem_we;
  assign mem.mem_be    = r_mem_be;
  assign mem.mem_addr  = r_mem_addr;
  assign mem.mem_wdata = r_mem_wdata;

  assign done_o      = w_resp;
  assign wb_valid_o  = w_wb;
  assign wb_rd_o     = w_wb ? r_rd : '0;
  assign wb_data_o   = w_wb ? r_wb_data : '0;
  assign err_valid_o = w_resp && r_err;
  assign err_cause_o = err_valid_o ? r_cause : '0;
  assign err_tval_o  = err_valid_o ? r_addr : '0;

endmodule
`default_nettype wire

// File: tb/tb_core_lsu.sv
`default_nettype none
// ============================================================================
// Module      : tb_core_lsu
// Description : Self-checking bench for core_lsu (TIMEOUT_CYCLES = 4). The
//               bench plays the memory and compares against an arithmetic
//               reference model of the load/store rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_core_lsu;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req_valid_i, req_ready_o, req_store_i;
  logic [2:0]  req_funct3_i;
  logic [31:0] req_addr_i, req_wdata_i;
  logic [4:0]  req_rd_i;
  logic        wb_valid_o, done_o, err_valid_o;
  logic [4:0]  wb_rd_o;
  logic [31:0] wb_data_o, err_tval_o;
  logic [3:0]  err_cause_o;

  int n_checks = 0;
  int n_err    = 0;

  core_lsu_if #(.XLEN(32)) mem_bus ();

  core_lsu #(.XLEN(32), .TIMEOUT_CYCLES(4)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_store_i  (req_store_i),
    .req_funct3_i (req_funct3_i),
    .req_addr_i   (req_addr_i),
    .req_wdata_i  (req_wdata_i),
    .req_rd_i     (req_rd_i),
    .mem          (mem_bus),
    .wb_valid_o   (wb_valid_o),
    .wb_rd_o      (wb_rd_o),
    .wb_data_o    (wb_data_o),
    .done_o       (done_o),
    .err_valid_o  (err_valid_o),
    .err_cause_o  (err_cause_o),
    .err_tval_o   (err_tval_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // ---------------- reference model ----------------
  function automatic int exp_cause(input logic st, input logic [2:0] f3, input logic [31:0] a);
    int size;
    if (st && f3 > 3'd2) return 2;
    if (!st && (f3 == 3'd3 || f3 > 3'd5)) return 2;
    size = int'(f3) % 4;
    if ((size == 1 && a % 2 != 0) || (size == 2 && a % 4 != 0)) return st ? 6 : 4;
    return 0;
  endfunction

  function automatic logic [3:0] exp_be(input logic [2:0] f3, input logic [31:0] a);
    int lane, size;
    lane = int'(a % 4);
    size = int'(f3) % 4;
    if (size == 0) return 4'(1 << lane);
    if (size == 1) return 4'(3 << lane);
    return 4'd15;
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] w);
    int size;
    size = int'(f3) % 4;
    if (size == 0) return (w % 256) * 32'h01010101;
    if (size == 1) return (w % 65536) * 32'h00010001;
    return w;
  endfunction

  function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] rd);
    logic [31:0] v;
    v = rd >> (8 * (a % 4));
    case (f3)
      3'd0: begin v = v % 256;   if (v >= 128)   v = v + 32'hFFFFFF00; end
      3'd4: v = v % 256;
      3'd1: begin v = v % 65536; if (v >= 32768) v = v + 32'hFFFF0000; end
      3'd5: v = v % 65536;
      default: v = rd;
    endcase
    return v;
  endfunction

  // One full operation: accept, optional memory phase, retirement.
  task automatic do_op(input logic st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic [4:0] rd,
                       input int gd, input int rvd, input logic [31:0] rdat);
    int cause;
    cause = exp_cause(st, f3, a);
    chk("ready_idle", 32'(req_ready_o), 32'd1);
    req_valid_i = 1'b1; req_store_i = st; req_funct3_i = f3;
    req_addr_i = a; req_wdata_i = wd; req_rd_i = rd;
    tick();
    req_valid_i = 1'b0; req_addr_i = $urandom; req_wdata_i = $urandom;
    req_funct3_i = 3'($urandom); req_rd_i = 5'($urandom);
    if (cause != 0) begin
      chk("err_no_req", 32'(mem_bus.mem_req), 32'd0);
      chk("err_done", 32'(done_o), 32'd1);
      chk("err_valid", 32'(err_valid_o), 32'd1);
      chk("err_cause", 32'(err_cause_o), 32'(cause));
      chk("err_tval", err_tval_o, a);
      chk("err_no_wb", 32'(wb_valid_o), 32'd0);
      tick();
    end else begin
      for (int g = 0; g <= gd; g++) begin
        chk("req_held", 32'(mem_bus.mem_req), 32'd1);
        chk("req_addr", mem_bus.mem_addr, a & 32'hFFFFFFFC);
        chk("req_be", 32'(mem_bus.mem_be), 32'(exp_be(f3, a)));
        chk("req_we", 32'(mem_bus.mem_we), 32'(st));
        if (st) chk("req_wdata", mem_bus.mem_wdata, exp_wdata(f3, wd));
        chk("req_no_done", 32'(done_o), 32'd0);
        mem_bus.mem_gnt = (g == gd);
        tick();
      end
      mem_bus.mem_gnt = 1'b0;
      for (int w = 0; w <= rvd; w++) begin
        chk("wait_no_req", 32'(mem_bus.mem_req), 32'd0);
        chk("wait_no_done", 32'(done_o), 32'd0);
        mem_bus.mem_rvalid = (w == rvd);
        mem_bus.mem_rdata  = (w == rvd) ? rdat : $urandom;
        tick();
      end
      mem_bus.mem_rvalid = 1'b0;
      mem_bus.mem_rdata  = $urandom;
      chk("resp_done", 32'(done_o), 32'd1);
      chk("resp_no_err", 32'(err_valid_o), 32'd0);
      chk("resp_cause0", 32'(err_cause_o), 32'd0);
      chk("resp_wb_valid", 32'(wb_valid_o), 32'(!st));
      if (!st) begin
        chk("resp_wb_rd", 32'(wb_rd_o), 32'(rd));
        chk("resp_wb_data", wb_data_o, exp_load(f3, a, rdat));
      end
      tick();
      chk("post_done", 32'(done_o), 32'd0);
    end
  endtask

  initial begin
    logic [2:0] ld_f3 [5];
    logic        st;
    logic [2:0]  f3;
    logic [31:0] a;
    ld_f3[0] = 3'd0; ld_f3[1] = 3'd1; ld_f3[2] = 3'd2; ld_f3[3] = 3'd4; ld_f3[4] = 3'd5;

    rst_i = 1'b1; req_valid_i = 1'b0; req_store_i = 1'b0; req_funct3_i = '0;
    req_addr_i = '0; req_wdata_i = '0; req_rd_i = '0;
    mem_bus.mem_gnt = 1'b0; mem_bus.mem_rvalid = 1'b0; mem_bus.mem_rdata = '0;
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_ready", 32'(req_ready_o), 32'd1);
    chk("rst_req", 32'(mem_bus.mem_req), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_wb", 32'(wb_valid_o), 32'd0);
    chk("rst_err", 32'(err_valid_o), 32'd0);
    chk("rst_be", 32'(mem_bus.mem_be), 32'd0);
    rst_i = 1'b0;
    tick();

    // Directed cases
    do_op(1'b0, 3'd2, 32'h100, 32'h0, 5'd5, 0, 0, 32'hDEADBEEF);   // LW
    do_op(1'b0, 3'd0, 32'h103, 32'h0, 5'd6, 0, 0, 32'h80FF0000);   // LB
    do_op(1'b0, 3'd4, 32'h103, 32'h0, 5'd7, 1, 1, 32'h80FF0000);   // LBU
    do_op(1'b1, 3'd1, 32'h202, 32'h0000ABCD, 5'd0, 3, 0, 32'h0);   // SH, late grant
    do_op(1'b0, 3'd1, 32'h6, 32'h0, 5'd8, 0, 2, 32'h80011234);     // LH upper half
    do_op(1'b0, 3'd5, 32'h6, 32'h0, 5'd0, 2, 0, 32'h80011234);     // LHU, rd 0
    do_op(1'b1, 3'd0, 32'h301, 32'h123456A5, 5'd0, 0, 3, 32'h0);   // SB
    do_op(1'b0, 3'd2, 32'h101, 32'h0, 5'd9, 0, 0, 32'h0);          // LW misaligned
    do_op(1'b1, 3'd3, 32'h40, 32'h0, 5'd0, 0, 0, 32'h0);           // illegal store
    do_op(1'b0, 3'd6, 32'h44, 32'h0, 5'd1, 0, 0, 32'h0);           // illegal load
    do_op(1'b0, 3'd1, 32'h3, 32'h0, 5'd2, 0, 0, 32'h0);            // LH misaligned
    do_op(1'b1, 3'd2, 32'h6, 32'h0, 5'd0, 0, 0, 32'h0);            // SW misaligned

    // Load never granted: fault after four REQ cycles
    req_valid_i = 1'b1; req_store_i = 1'b0; req_funct3_i = 3'd2;
    req_addr_i = 32'h300; req_rd_i = 5'd3;
    tick();
    req_valid_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("to_req_held", 32'(mem_bus.mem_req), 32'd1);
      tick();
    end
    chk("to_req_drop", 32'(mem_bus.mem_req), 32'd0);
    chk("to_done", 32'(done_o), 32'd1);
    chk("to_err", 32'(err_valid_o), 32'd1);
    chk("to_cause", 32'(err_cause_o), 32'd5);
    chk("to_tval", err_tval_o, 32'h300);
    chk("to_no_wb", 32'(wb_valid_o), 32'd0);
    tick();
    mem_bus.mem_rvalid = 1'b1;   // stray response while idle
    tick();
    mem_bus.mem_rvalid = 1'b0;
    chk("stray_done", 32'(done_o), 32'd0);
    chk("stray_wb", 32'(wb_valid_o), 32'd0);
    chk("stray_ready", 32'(req_ready_o), 32'd1);
    tick();
    chk("stray_done2", 32'(done_o), 32'd0);

    // Store granted but never answered: fault after four WAIT cycles
    req_valid_i = 1'b1; req_store_i = 1'b1; req_funct3_i = 3'd2;
    req_addr_i = 32'h400; req_wdata_i = 32'h11223344;
    tick();
    req_valid_i = 1'b0;
    mem_bus.mem_gnt = 1'b1;
    tick();
    mem_bus.mem_gnt = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("tow_no_done", 32'(done_o), 32'd0);
      tick();
    end
    chk("tow_done", 32'(done_o), 32'd1);
    chk("tow_cause", 32'(err_cause_o), 32'd7);
    chk("tow_tval", err_tval_o, 32'h400);
    mem_bus.mem_rvalid = 1'b1;   // late response
    tick();
    mem_bus.mem_rvalid = 1'b0;
    chk("late_done", 32'(done_o), 32'd0);
    chk("late_ready", 32'(req_ready_o), 32'd1);

    // Reset in the middle of WAIT
    req_valid_i = 1'b1; req_store_i = 1'b0; req_funct3_i = 3'd2;
    req_addr_i = 32'h500; req_rd_i = 5'd4;
    tick();
    req_valid_i = 1'b0;
    mem_bus.mem_gnt = 1'b1;
    tick();
    mem_bus.mem_gnt = 1'b0;
    #2 rst_i = 1'b1;
    #1;
    chk("arst_req", 32'(mem_bus.mem_req), 32'd0);
    chk("arst_ready", 32'(req_ready_o), 32'd1);
    chk("arst_done", 32'(done_o), 32'd0);
    chk("arst_wb", 32'(wb_valid_o), 32'd0);
    chk("arst_err", 32'(err_valid_o), 32'd0);
    tick();
    rst_i = 1'b0;
    tick();
    do_op(1'b0, 3'd2, 32'h504, 32'h0, 5'd4, 0, 0, 32'hCAFEF00D);

    // Randomized operations
    for (int n = 0; n < 60; n++) begin
      st = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) f3 = 3'($urandom_range(0, 7));
      else f3 = st ? 3'($urandom_range(0, 2)) : ld_f3[$urandom_range(0, 4)];
      a = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (f3[1:0] == 2'b10) a = a & 32'hFFFFFFFC;
        else if (f3[1:0] == 2'b01) a = a & 32'hFFFFFFFE;
      end
      do_op(st, f3, a, $urandom, 5'($urandom), $urandom_range(0, 3),
            $urandom_range(0, 3), $urandom);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
